butterfly_array: RTL
====================

Name: butterfly_array

Overview:
Parametrised radix-2 FFT butterfly with B independent lanes sharing one val/rdy handshake. Per lane it computes t = b*w (or b*conj(w) in inverse mode), then c = a + t and d = a - t, with an optional divide-by-2 output scaling. It is the next-generation butterfly for the FFT datapath: the same fixed-point format, plus multi-lane throughput, an inverse-transform mode, per-stage scaling and fully registered, held outputs.

Parameters:
n, 32, total bit width of each signed fixed-point component
d, 16, fractional bits (1.0 = 1<<d)
B, 1, number of parallel butterfly lanes

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
recv_val  input  1  input bundle valid
recv_rdy  output  1  block can accept a bundle
inv  input  1  inverse mode; sampled on accept; 1 = use conj(w)
scale  input  1  scaling; sampled on accept; 1 = outputs arithmetically shifted right by 1
ar, ac, br, bc, wr, wc  input  B*n  lane i in bits [i*n +: n]; real/imag parts of a, b, w
send_val  output  1  result bundle valid
send_rdy  input  1  downstream ready
cr, cc, dr, dc  output  B*n  lane i in bits [i*n +: n]; registered results

Behaviour:
- FSM states: IDLE, MUL, DONE. Reset forces IDLE: recv_rdy=1, send_val=0, cr/cc/dr/dc=0. Reset has priority over every other event.
- recv_rdy=1 only in IDLE; send_val=1 only in DONE. Both are registered outputs.
- IDLE: on recv_val&recv_rdy, register all a/b/w lanes, inv and scale, then go to MUL. Inputs have no effect while not in IDLE.
- MUL: each lane runs its own sequential complex multiplier. Stay in MUL until all B lanes report done, then write the outputs and go to DONE.
- Multiply rule: P(x,y) = full 2n-bit signed product, arithmetically shifted right by d (floor), truncated to n bits.
- Complex multiply: tr = P(br,wr) - P(bc,w'c); tc = P(br,w'c) + P(bc,wr).
- w'c = wc normally; w'c = -wc (two's complement, mod 2^n) when inv=1.
- Unscaled outputs: cr = ar+tr, cc = ac+tc, dr = ar-tr, dc = ac-tc, all mod 2^n (wrap, no saturation).
- Scaled outputs: each sum/difference is formed in n+1 bits, arithmetically shifted right by 1 and truncated to n bits. This cannot overflow.
- Latency from accept to send_val: >=2 cycles and <=n+4 cycles. It is the same for every lane of a bundle; the bench must rely only on the handshake.
- DONE: outputs and send_val are held stable until send_rdy=1. On send_val&send_rdy, go to IDLE (recv_rdy=1 the next cycle). There is no same-cycle accept in DONE.
- Reset asserted in MUL or DONE aborts the operation: the result is discarded and the next cycle is IDLE with outputs zeroed.
- Lanes are fully independent; overflow in one lane does not affect the others.

Test Plan:
1. n=32, d=16, B=1, inv=0, scale=0: a=(0x00010000,0), b=(0x00020000,0), w=(0x00010000,0) -> c=(0x00030000,0), d=(0xFFFF0000,0); send_val within 36 cycles.
2. Inverse mode: a=(0,0), b=(0,0x00010000), w=(0,0x00010000); inv=0 -> c=(0xFFFF0000,0), d=(0x00010000,0); same inputs with inv=1 -> c=(0x00010000,0), d=(0xFFFF0000,0).
3. Scaling and wrap: a=(0x7FFFFFFF,0), b=(0x00000001,0), w=(0x00010000,0).
   - scale=0 -> cr=0x80000000 (wrapped), dr=0x7FFFFFFE.
   - scale=1 -> cr=0x40000000, dr=0x3FFFFFFF.
4. Backpressure: hold send_rdy=0 for 10 cycles after send_val rises -> outputs and send_val stay constant, recv_rdy=0, and a new recv_val is ignored. Raising send_rdy for one cycle -> send_val=0 and recv_rdy=1 on the next cycle.
5. B=4, distinct per-lane values (lane i: a=(i<<16,0), b=(1<<16,0), w=(0x00010000,0)) -> lane i: c=((i+1)<<16,0), d=((i-1)<<16 mod 2^32,0); one send_val for the whole bundle.
6. Reset mid-MUL, 3 cycles after accept -> the next cycle shows recv_rdy=1, send_val=0, outputs 0; a subsequent transaction completes correctly (rerun scenario 1).

Source files
------------

// File: rtl/butterfly_if.sv
// butterfly_if: val/rdy bundle carrying B lanes of butterfly operands and results
interface butterfly_if #(parameter int n = 32, parameter int B = 1);
  logic recv_val, recv_rdy, inv, scale, send_val, send_rdy;
  logic [B*n-1:0] ar, ac, br, bc, wr, wc, cr, cc, dr, dc;
  modport master(
    output recv_val, inv, scale, ar, ac, br, bc, wr, wc, send_rdy,
    input recv_rdy, send_val, cr, cc, dr, dc
  );
  modport slave(
    input recv_val, inv, scale, ar, ac, br, bc, wr, wc, send_rdy,
    output recv_rdy, send_val, cr, cc, dr, dc
  );
endinterface

// File: rtl/butterfly_array.sv
// butterfly_array: B-lane radix-2 FFT butterfly, sequential shift-add complex multiply per lane
module butterfly_array #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int B = 1
) (
  input logic clk,
  input logic reset,
  butterfly_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int CW = $clog2(n + 1);
  state_t state, state_n;
  logic accept, finish;
  logic scale_q;
  logic [B-1:0] lane_done;
  logic [B*n-1:0] a_r, a_c, cr_n, cc_n, dr_n, dc_n;
  function automatic logic [2*n-1:0] mac(input logic [2*n-1:0] p, x, input logic bit_, last);
    return bit_ ? (last ? p - x : p + x) : p;
  endfunction
  function automatic logic [n-1:0] addsub(input logic [n-1:0] a, t, input logic sub, sc);
    logic [n:0] s = sub ? {a[n-1], a} - {t[n-1], t} : {a[n-1], a} + {t[n-1], t};
    return sc ? s[n:1] : s[n-1:0];
  endfunction
  assign accept = state == IDLE && bus.recv_val;
  assign finish = state == MUL && &lane_done;
  assign bus.recv_rdy = state == IDLE;
  assign bus.send_val = state == DONE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = MUL;
    else if (finish) state_n = DONE;
    else if (state == DONE && bus.send_rdy) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.ar;
      a_c <= bus.ac;
      scale_q <= bus.scale;
    end
    if (reset) begin
      bus.cr <= '0;
      bus.cc <= '0;
      bus.dr <= '0;
      bus.dc <= '0;
    end else if (finish) begin
      bus.cr <= cr_n;
      bus.cc <= cc_n;
      bus.dr <= dr_n;
      bus.dc <= dc_n;
    end
  end
  for (genvar i = 0; i < B; i++) begin : g_lane
    logic [2*n-1:0] xr, xc, p_rr, p_cc, p_rc, p_cr;
    logic [n-1:0] yr, yc, tr, tc;
    logic [CW-1:0] cnt;
    logic last, unused_bits;
    assign last = cnt == CW'(n - 1);
    assign lane_done[i] = cnt == CW'(n);
    // The MSB of a two's-complement multiplier carries negative weight, so the last step subtracts.
    always_ff @(posedge clk) begin
      if (accept) begin
        xr <= {{n{bus.br[i*n+n-1]}}, bus.br[i*n +: n]};
        xc <= {{n{bus.bc[i*n+n-1]}}, bus.bc[i*n +: n]};
        yr <= bus.wr[i*n +: n];
        yc <= bus.inv ? -bus.wc[i*n +: n] : bus.wc[i*n +: n];
        p_rr <= '0;
        p_cc <= '0;
        p_rc <= '0;
        p_cr <= '0;
        cnt <= '0;
      end else if (state == MUL && !lane_done[i]) begin
        p_rr <= mac(p_rr, xr, yr[0], last);
        p_cr <= mac(p_cr, xc, yr[0], last);
        p_rc <= mac(p_rc, xr, yc[0], last);
        p_cc <= mac(p_cc, xc, yc[0], last);
        xr <= xr << 1;
        xc <= xc << 1;
        yr <= yr >> 1;
        yc <= yc >> 1;
        cnt <= cnt + CW'(1);
      end
    end
    assign tr = p_rr[d +: n] - p_cc[d +: n];
    assign tc = p_rc[d +: n] + p_cr[d +: n];
    assign cr_n[i*n +: n] = addsub(a_r[i*n +: n], tr, 1'b0, scale_q);
    assign cc_n[i*n +: n] = addsub(a_c[i*n +: n], tc, 1'b0, scale_q);
    assign dr_n[i*n +: n] = addsub(a_r[i*n +: n], tr, 1'b1, scale_q);
    assign dc_n[i*n +: n] = addsub(a_c[i*n +: n], tc, 1'b1, scale_q);
    assign unused_bits = ^{p_rr[2*n-1:n+d], p_rr[d-1:0], p_cc[2*n-1:n+d], p_cc[d-1:0],
                           p_rc[2*n-1:n+d], p_rc[d-1:0], p_cr[2*n-1:n+d], p_cr[d-1:0]};
  end
endmodule
